drum_step_sequencer: RTL

DRUM_STEP_SEQUENCER -- requirements
Module: drum_step_sequencer

---
 rtl/drum_step_sequencer.sv | 134 +++++++++++++
 1 files changed

// File: rtl/drum_step_sequencer.sv
// Pattern-driven drum step sequencer with per-voice trigger pulses and a
// descending pitch sweep started by the sweep voice's trigger.
module drum_step_sequencer #(
  parameter int NUM_VOICES    = 3,
  parameter int NUM_STEPS     = 16,
  parameter int TICK_BITS     = 24,
  parameter int FREQ_RES_BITS = 8,
  parameter int SWEEP_VOICE   = 1
) (
  input  logic                         mclk,
  input  logic                         rst,
  input  logic                         run,
  input  logic [TICK_BITS-1:0]         tempo_div,
  input  logic                         pat_we,
  input  logic [$clog2(NUM_VOICES)-1:0] pat_voice,
  input  logic [NUM_STEPS-1:0]         pat_data,
  input  logic [NUM_VOICES-1:0]        man_trig,
  input  logic [FREQ_RES_BITS-1:0]     sweep_start,
  input  logic [FREQ_RES_BITS-1:0]     sweep_end,
  input  logic [7:0]                   sweep_div,
  output logic [NUM_VOICES-1:0]        trig,
  output logic [$clog2(NUM_STEPS)-1:0] step_idx,
  output logic                         playing,
  output logic [FREQ_RES_BITS-1:0]     sweep_freq,
  output logic                         sweep_active
);

  localparam int VW = $clog2(NUM_VOICES);
  localparam int SW = $clog2(NUM_STEPS);
  localparam logic [TICK_BITS-1:0]     TICK_ONE = {{(TICK_BITS-1){1'b0}}, 1'b1};
  localparam logic [SW-1:0]            STEP_ONE = {{(SW-1){1'b0}}, 1'b1};
  localparam logic [FREQ_RES_BITS-1:0] FREQ_ONE = {{(FREQ_RES_BITS-1){1'b0}}, 1'b1};

  typedef enum logic {IDLE, RUN} state_t;

  state_t                 state;
  logic [TICK_BITS-1:0]   tick_cnt;
  logic [TICK_BITS-1:0]   tick_lim;
  logic                   tick_last;
  logic [NUM_STEPS-1:0]   pattern [NUM_VOICES];
  logic [NUM_VOICES-1:0]  seq_req;
  logic [7:0]             sweep_cnt;

  // A counter already past a shortened limit runs on to its natural wrap,
  // which also ends the step.
  always_comb begin
    tick_lim  = (tempo_div == '0) ? TICK_ONE : tempo_div;
    tick_last = (tick_cnt == tick_lim - TICK_ONE) || (tick_cnt == '1);
  end

  always_comb begin
    seq_req = '0;
    if (state == RUN && tick_cnt == '0) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        seq_req[v] = pattern[v][step_idx];
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      playing  <= 1'b0;
      tick_cnt <= '0;
      step_idx <= '0;
      trig     <= '0;
    end else begin
      trig <= seq_req | man_trig;
      case (state)
        IDLE: begin
          tick_cnt <= '0;
          step_idx <= '0;
          if (run) begin
            state   <= RUN;
            playing <= 1'b1;
          end
        end
        RUN: begin
          if (!run) begin
            state    <= IDLE;
            playing  <= 1'b0;
            tick_cnt <= '0;
            step_idx <= '0;
          end else if (tick_last) begin
            tick_cnt <= '0;
            step_idx <= step_idx + STEP_ONE;
          end else begin
            tick_cnt <= tick_cnt + TICK_ONE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Rows update at the write edge, so a request in the same cycle sees the old row.
  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) pattern[v] <= '0;
    end else if (pat_we) begin
      for (int unsigned v = 0; v < NUM_VOICES; v++) begin
        if (pat_voice == VW'(v)) pattern[v] <= pat_data;
      end
    end
  end

  always_ff @(posedge mclk or posedge rst) begin
    if (rst) begin
      sweep_freq   <= '0;
      sweep_active <= 1'b0;
      sweep_cnt    <= '0;
    end else if (trig[SWEEP_VOICE]) begin
      sweep_cnt <= '0;
      if (sweep_start > sweep_end) begin
        sweep_freq   <= sweep_start;
        sweep_active <= 1'b1;
      end else begin
        sweep_freq   <= sweep_end;
        sweep_active <= 1'b0;
      end
    end else if (sweep_active) begin
      if (sweep_freq <= sweep_end) begin
        sweep_active <= 1'b0;
      end else if (sweep_cnt == sweep_div) begin
        sweep_cnt  <= '0;
        sweep_freq <= sweep_freq - FREQ_ONE;
        if (sweep_freq - FREQ_ONE == sweep_end) sweep_active <= 1'b0;
      end else begin
        sweep_cnt <= sweep_cnt + 8'd1;
      end
    end
  end

endmodule
